// File: rtl/kgp_register_file.sv
// KGP_RISC 32x32 architectural register file with r0 hardwired to zero, debug valid mask and saturating write counter.
// Optional same-cycle write forwarding to the read ports is enabled by defining KGP_RF_WRITE_BYPASS_EN.
module kgp_register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      rsAddr,
  input  logic [ADDR_W-1:0]      rtAddr,
  input  logic [ADDR_W-1:0]      wrAddr,
  input  logic [DATA_W-1:0]      wrData,
  input  logic                   RegWrite,
  output logic [DATA_W-1:0]      rsData,
  output logic [DATA_W-1:0]      rtData,
  output logic [DATA_W-1:0]      ra,
  output logic [2**ADDR_W-1:0]   regValid,
  output logic [CNT_W-1:0]       wrCount
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              commit;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

  // Writes to r0 are dropped entirely, so they never touch the debug state either.
  assign commit = RegWrite && (wrAddr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      regValid <= '0;
      wrCount  <= '0;
    end else if (commit) begin
      regs[wrAddr]     <= wrData;
      regValid[wrAddr] <= 1'b1;
      wrCount          <= satInc(wrCount);
    end
  end

  function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] addr);
    if (addr == '0) return '0;
`ifdef KGP_RF_WRITE_BYPASS_EN
    if (commit && (addr == wrAddr)) return wrData;
`endif
    return regs[addr];
  endfunction

  assign rsData = readPort(rsAddr);
  assign rtData = readPort(rtAddr);
  assign ra     = readPort(LINK_ADDR);

endmodule

// File: doc/kgp_register_file.md
Name: kgp_register_file

Overview:
- 32 x 32-bit architectural register file for KGP_RISC, directly downstream of the writeback select stage.
- Consumes that stage's wrAddr / wrData / RegWrite on each rising clock edge.
- Serves two combinational read ports (rs, rt) to decode/ALU operand fetch, and exposes the link register (r31) as ra back to the writeback select stage.
- Keeps a written-since-reset bitmask and a saturating write counter for debug.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- CNT_W, 16, width of the saturating write counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rsAddr  input  ADDR_W  read port A address.
- rtAddr  input  ADDR_W  read port B address.
- wrAddr  input  ADDR_W  write address from the writeback select stage.
- wrData  input  DATA_W  write data from the writeback select stage.
- RegWrite  input  1  write enable from the writeback select stage.
- rsData  output  DATA_W  read port A data, combinational.
- rtData  output  DATA_W  read port B data, combinational.
- ra  output  DATA_W  current contents of r31 (link register), combinational.
- regValid  output  2**ADDR_W  bit i = 1 once register i has been written since reset.
- wrCount  output  CNT_W  number of committed writes since reset, saturating.

Behaviour:
- Reset is asynchronous and active-low.
- While rst_n = 0, all registers are cleared to 0, regValid = 0 and wrCount = 0. As a result rsData = rtData = ra = 0.
- Reset asserted mid-write: the write is lost. No partial state survives.
- Write (commit): on a rising clk edge with rst_n = 1, RegWrite = 1 and wrAddr != 0:
  - regs[wrAddr] <= wrData;
  - regValid[wrAddr] <= 1;
  - wrCount increments by 1.
- r0 is hardwired to zero:
  - A write to address 0 is discarded. regValid[0] and wrCount are unchanged.
  - Reads of address 0 always return 0.
- RegWrite = 0: no state changes. wrAddr and wrData are don't-care.
- wrCount saturates at 2**CNT_W - 1 and never wraps.
- Reads are combinational from the current register contents. Latency is 0 cycles for reads and 1 edge for writes.
- Both read ports and ra may address the same register simultaneously. Each returns identical data.
- Same-cycle read and write of the same address: behaviour depends on the optional feature (see below).
- regValid is sticky until the next reset.
- Writing the same value twice still counts twice in wrCount.
- No X propagation on outputs after reset is released: every storage element has a reset value.

Optional Feature:
- Macro: KGP_RF_WRITE_BYPASS_EN.
- Defined: internal forwarding. If RegWrite = 1, wrAddr != 0 and a read address equals wrAddr, that read output (rsData, rtData, or ra when wrAddr = 31) returns wrData combinationally in the same cycle.
- Not defined: reads return the pre-edge stored value. The written value becomes visible only after the rising edge.
- Forwarding never applies to address 0.
- Forwarding does not change regValid or wrCount timing.

Test Plan:
- Reset: drive rst_n = 0 asynchronously between clock edges after writing r5 = 32'hDEADBEEF -> rsData(r5) = 0, regValid = 0 and wrCount = 0 immediately, with no clock edge required.
- Basic write/read: RegWrite = 1, wrAddr = 7, wrData = 70, one edge, then rsAddr = 7, rtAddr = 7 -> rsData = rtData = 70, regValid = 32'h0000_0080, wrCount = 1.
- r0 protection: RegWrite = 1, wrAddr = 0, wrData = 100, one edge -> rsAddr = 0 returns 0, regValid[0] = 0, wrCount unchanged.
- Link register: write wrAddr = 31, wrData = 100, one edge -> ra = 100 and rtData(rtAddr = 31) = 100. Hold RegWrite = 0 for 5 edges -> ra stays 100, wrCount unchanged.
- Bypass, same-cycle read of the address being written (rsAddr = wrAddr = 9, wrData = 55, old r9 = 3, RegWrite = 1, checked before the edge):
  - built with KGP_RF_WRITE_BYPASS_EN -> rsData = 55;
  - built without it -> rsData = 3, and rsData = 55 after the edge.
- Saturation: build with CNT_W = 4, perform 20 writes to r1 -> wrCount = 15 and holds there; r1 holds the last wrData.
